sha256_24bit_in: RTL and testbench
==================================

Name: sha256_24bit_in

Overview:
- Single-block SHA-256 hash engine for a fixed 24-bit (3-byte) message, per FIPS 180-4.
- On a valid strobe it captures msg_in, pads it internally to one 512-bit block, and runs 64 compression rounds at one round per clock.
- When the digest is complete it presents the 256-bit result with a ready flag.
- Used as a leaf hashing unit fed by a simple valid-qualified source.

Parameters:
- None. Message length is fixed at 24 bits.
- Round constants K[0..63] and initial hash H0..H7 are hard-coded FIPS 180-4 values.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, asynchronous and active-low; one clock domain
- valid  input  1  start request; msg_in is sampled when valid=1 and the engine is not busy
- msg_in  input  24  message bytes, big-endian; msg_in[23:16] is byte 0
- msg_out  output  256  digest, H0 in [255:224] down to H7 in [31:0]
- ready  output  1  high while msg_out holds a completed digest

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, ready=0, msg_out=0, round counter=0.
  - Working registers a..h and the message window are cleared.
  - Asserting reset mid-hash aborts the hash with no output.
- States and transitions:
  - IDLE: if valid=1 at a rising edge, capture the block, load a..h from H0..H7, set counter=0, clear ready, go to BUSY.
  - BUSY: each edge applies round t=counter, then counter++. valid and msg_in are ignored.
  - Round 63: the same edge also writes msg_out = {H0+a', ..., H7+h'} mod 2^32 per word (a'..h' are the post-round-63 values), sets ready=1, and goes to DONE.
  - DONE: msg_out and ready hold. If valid=1 at an edge, capture a new message exactly as in IDLE; ready drops to 0 on that same edge. If valid=0, remain in DONE.
- Latency:
  - ready rises on the 64th rising edge after the capture edge.
  - With valid held high, a new hash starts one cycle after ready rises, so ready is a 1-cycle pulse and each hash occupies 65 cycles.
- Padded block:
  - W0 = {msg_in, 8'h80}
  - W1..W14 = 0
  - W15 = 32'h00000018 (bit length 24)
- Message schedule:
  - Rolling 16-word window.
  - For t<16, use Wt directly.
  - For t≥16, Wt = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], mod 2^32.
  - σ0 = ROTR7^ROTR18^SHR3; σ1 = ROTR17^ROTR19^SHR10.
- Round function:
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[t]
  - T2 = Σ0(a) + Maj(a,b,c)
  - Σ0 = ROTR2^13^22; Σ1 = ROTR6^11^25.
  - Update: h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2.
  - All additions are 32-bit and wrap; carries are discarded.
- msg_in changes while BUSY have no effect on the result in progress.
- ready never asserts without a preceding capture.

Test Plan:
- Reset then "abc": hold rst=0 for 2 cycles, release, pulse valid with msg_in=24'h616263. Require ready=1 exactly 64 edges after capture, and msg_out = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Zero message: msg_in=24'h000000. Require msg_out equal to a software SHA-256 model of bytes {00,00,00}; ready and msg_out hold while valid=0.
- Back-to-back with valid held high: sequence FFFFFF, C3AA0F, FF00FF, 00FF00, E21D55, 7E81F5, 696969, C33CCC, each applied in DONE. Require each digest to match the software model, and ready to drop on each restart edge.
- Input disturbance: toggle msg_in and valid every cycle during BUSY after capturing "abc". Require the digest to still equal ba7816bf…f20015ad, completing at the same edge.
- Reset mid-hash: capture "abc", assert rst at round 30. Require ready=0 and msg_out=0 immediately (asynchronous). After release, a fresh capture yields the correct digest.
- Idle without valid after reset: require ready to stay 0 and msg_out to stay 0 for 200 cycles.

Source files
------------

// File: rtl/sha256_24bit_in.sv
`default_nettype none
// ============================================================================
// Module   : sha256_24bit_in
// Purpose  : Single-block SHA-256 engine for a fixed 3-byte message. The
//            message is padded internally to one 512-bit block and
//            compressed at one round per clock (64 rounds).
// Ports    : clk     - system clock, rising edge
//            rst     - asynchronous reset, active low
//            valid   - start request, sampled when not busy
//            msg_in  - 24-bit message, msg_in[23:16] is byte 0
//            msg_out - 256-bit digest, H0 in [255:224] .. H7 in [31:0]
//            ready   - high while msg_out holds a completed digest
// Revision : 1.0 - initial release
// ============================================================================
module sha256_24bit_in (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  input  logic [23:0]  msg_in,
  output logic [255:0] msg_out,
  output logic         ready
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_busy = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  localparam logic [31:0] c_k [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] c_h0 = 32'h6a09e667;
  localparam logic [31:0] c_h1 = 32'hbb67ae85;
  localparam logic [31:0] c_h2 = 32'h3c6ef372;
  localparam logic [31:0] c_h3 = 32'ha54ff53a;
  localparam logic [31:0] c_h4 = 32'h510e527f;
  localparam logic [31:0] c_h5 = 32'h9b05688c;
  localparam logic [31:0] c_h6 = 32'h1f83d9ab;
  localparam logic [31:0] c_h7 = 32'h5be0cd19;

  function automatic logic [31:0] rotr(input logic [31:0] x, input logic [4:0] n);
    return (x >> n) | (x << (6'd32 - {1'b0, n}));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 5'd2) ^ rotr(x, 5'd13) ^ rotr(x, 5'd22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 5'd6) ^ rotr(x, 5'd11) ^ rotr(x, 5'd25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 5'd7) ^ rotr(x, 5'd18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 5'd17) ^ rotr(x, 5'd19) ^ (x >> 10);
  endfunction

  logic [1:0]   r_state;
  logic [1:0]   w_next_state;
  logic [5:0]   r_round;
  logic [31:0]  r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
  // Rolling schedule window: r_w[0] is W[t] for the round being applied.
  logic [31:0]  r_w [0:15];
  logic [255:0] r_digest;

  logic         w_start;
  logic         w_busy;
  logic         w_last;
  logic [31:0]  w_t1;
  logic [31:0]  w_t2;
  logic [31:0]  w_new_a;
  logic [31:0]  w_new_e;
  logic [31:0]  w_w_next;

  assign w_start = valid && ((r_state == c_st_idle) || (r_state == c_st_done));
  assign w_busy  = (r_state == c_st_busy);
  assign w_last  = w_busy && (r_round == 6'd63);

  assign w_t1    = r_h + big_sigma1(r_e) + ((r_e & r_f) ^ (~r_e & r_g))
                 + c_k[r_round] + r_w[0];
  assign w_t2    = big_sigma0(r_a) + ((r_a & r_b) ^ (r_a & r_c) ^ (r_b & r_c));
  assign w_new_a = w_t1 + w_t2;
  assign w_new_e = r_d + w_t1;

  // Window entry r_w[0] is W[t]; shifting in W[t+16] from the current window
  // uses the same recurrence for every round. Words computed past W[63] are
  // simply never consumed.
  assign w_w_next = small_sigma1(r_w[14]) + r_w[9] + small_sigma0(r_w[1]) + r_w[0];

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: if (valid)                 w_next_state = c_st_busy;
      c_st_busy: if (r_round == 6'd63)      w_next_state = c_st_done;
      c_st_done: if (valid)                 w_next_state = c_st_busy;
      default:                              w_next_state = c_st_idle;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    ready   = (r_state == c_st_done);
    msg_out = r_digest;
  end

  // --------------------------------------------------------------------------
  // Datapath: capture, compression rounds and digest
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_round  <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_d      <= '0;
      r_e      <= '0;
      r_f      <= '0;
      r_g      <= '0;
      r_h      <= '0;
      r_digest <= '0;
      for (int i = 0; i < 16; i++) begin
        r_w[i] <= '0;
      end
    end else if (w_start) begin
      // Padded block: message, 0x80 terminator, zeros, bit length 24.
      r_w[0] <= {msg_in, 8'h80};
      for (int i = 1; i < 15; i++) begin
        r_w[i] <= '0;
      end
      r_w[15] <= 32'd24;
      r_round <= '0;
      r_a     <= c_h0;
      r_b     <= c_h1;
      r_c     <= c_h2;
      r_d     <= c_h3;
      r_e     <= c_h4;
      r_f     <= c_h5;
      r_g     <= c_h6;
      r_h     <= c_h7;
    end else if (w_busy) begin
      r_a <= w_new_a;
      r_b <= r_a;
      r_c <= r_b;
      r_d <= r_c;
      r_e <= w_new_e;
      r_f <= r_e;
      r_g <= r_f;
      r_h <= r_g;
      for (int i = 0; i < 15; i++) begin
        r_w[i] <= r_w[i + 1];
      end
      r_w[15] <= w_w_next;
      r_round <= r_round + 6'd1;
      // Final round: fold the post-round working values into the IV.
      if (w_last) begin
        r_digest <= {c_h0 + w_new_a, c_h1 + r_a, c_h2 + r_b, c_h3 + r_c,
                     c_h4 + w_new_e, c_h5 + r_e, c_h6 + r_f, c_h7 + r_g};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha256_24bit_in.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_24bit_in
// Purpose  : Self-checking bench for sha256_24bit_in. Expected digests come
//            from a reference SHA-256 routine and are queued at capture time,
//            then compared when ready rises.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_24bit_in;

  localparam logic [255:0] c_abc_digest =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  localparam logic [31:0] c_kt [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk;
  logic         rst;
  logic         valid;
  logic [23:0]  msg_in;
  logic [255:0] msg_out;
  logic         ready;

  int n_vec;
  int n_err;
  logic [255:0] sb [$];
  logic [255:0] last_exp;

  sha256_24bit_in dut (
    .clk     (clk),
    .rst     (rst),
    .valid   (valid),
    .msg_in  (msg_in),
    .msg_out (msg_out),
    .ready   (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: textbook SHA-256 over a full 64-word schedule.
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_model(input logic [23:0] m);
    logic [31:0] w [64];
    logic [31:0] iv [8];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    iv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    w[0] = {m, 8'h80};
    for (int t = 1; t < 15; t++) w[t] = 32'h0;
    w[15] = 32'h00000018;
    for (int t = 16; t < 64; t++) begin
      w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    end
    a = iv[0]; b = iv[1]; c = iv[2]; d = iv[3];
    e = iv[4]; f = iv[5]; g = iv[6]; h = iv[7];
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + c_kt[t] + w[t];
      t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {iv[0] + a, iv[1] + b, iv[2] + c, iv[3] + d,
            iv[4] + e, iv[5] + f, iv[6] + g, iv[7] + h};
  endfunction

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called right after a capture edge: waits for ready, checks the latency
  // (64 edges) and the digest against the head of the scoreboard.
  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int n = 1; n <= 70 && !seen; n++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        seen = 1'b1;
        check({tag, "_latency"}, 256'(n), 256'd64);
        if (sb.size() == 0) begin
          check({tag, "_sb_empty"}, 256'd1, 256'd0);
        end else begin
          last_exp = sb.pop_front();
          check({tag, "_digest"}, msg_out, last_exp);
        end
      end
    end
    if (!seen) check({tag, "_timeout"}, {255'd0, ready}, 256'd1);
  endtask

  // Drive a message at the falling edge and capture it on the next rising edge.
  task automatic capture(input logic [23:0] m, input bit push);
    @(negedge clk);
    valid  = 1'b1;
    msg_in = m;
    @(posedge clk);
    if (push) sb.push_back(sha_model(m));
    #1;
    valid = 1'b0;
  endtask

  logic [23:0] seq [8];

  initial begin
    n_vec  = 0;
    n_err  = 0;
    rst    = 1'b1;
    valid  = 1'b0;
    msg_in = 24'h0;
    seq = '{24'hFFFFFF, 24'hC3AA0F, 24'hFF00FF, 24'h00FF00,
            24'hE21D55, 24'h7E81F5, 24'h696969, 24'hC33CCC};

    // Reset for two cycles
    #3 rst = 1'b0;
    #1;
    check("reset_ready", {255'd0, ready}, 256'd0);
    check("reset_msg_out", msg_out, 256'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Idle without valid: nothing may appear
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      check("idle_ready", {255'd0, ready}, 256'd0);
      check("idle_msg_out", msg_out, 256'd0);
    end

    // "abc": known-answer digest queued directly
    capture(24'h616263, 1'b0);
    sb.push_back(c_abc_digest);
    wait_done("abc");

    // Zero message, then hold while valid stays low
    capture(24'h000000, 1'b1);
    check("zero_restart_ready", {255'd0, ready}, 256'd0);
    wait_done("zero");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("hold_ready", {255'd0, ready}, 256'd1);
      check("hold_msg_out", msg_out, last_exp);
    end

    // Back-to-back with valid held high
    @(negedge clk);
    valid  = 1'b1;
    msg_in = seq[0];
    @(posedge clk);
    sb.push_back(sha_model(seq[0]));
    #1;
    check("b2b_drop", {255'd0, ready}, 256'd0);
    for (int i = 0; i < 8; i++) begin
      if (i < 7) msg_in = seq[i + 1];
      else       valid  = 1'b0;
      wait_done("b2b");
      if (i < 7) begin
        @(posedge clk);
        sb.push_back(sha_model(seq[i + 1]));
        #1;
        check("b2b_drop", {255'd0, ready}, 256'd0);
      end
    end

    // Disturb inputs during the hash
    capture(24'h616263, 1'b0);
    sb.push_back(c_abc_digest);
    fork
      wait_done("disturb");
      begin
        repeat (63) begin
          @(negedge clk);
          valid  = ~valid;
          msg_in = 24'($urandom);
        end
        @(negedge clk);
        valid = 1'b0;
      end
    join

    // Reset mid-hash at round 30
    capture(24'h616263, 1'b0);
    repeat (30) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_ready", {255'd0, ready}, 256'd0);
    check("midrst_msg_out", msg_out, 256'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (70) begin
      @(posedge clk);
      #1;
      check("midrst_no_ready", {255'd0, ready}, 256'd0);
    end
    capture(24'h616263, 1'b0);
    sb.push_back(c_abc_digest);
    wait_done("after_rst");

    check("sb_drained", 256'(sb.size()), 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
